// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning HI/LO.
//   Executes mult/multu/div/divu with a fixed busy countdown, then commits the
//   latched result to HI/LO. mthi/mtlo write HI/LO on the next edge, without a countdown.
//   Ports:
//     clk       clock; all state updates on the rising edge
//     reset     synchronous, active-low
//     start     MduStart from the E-stage instruction
//     mdu_type  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO
//     cancel    exception/interrupt this cycle; suppresses start
//     rs_val    dividend / multiplicand / mt source
//     rt_val    divisor / multiplier
//     busy      operation in flight (registered-derived)
//     hi, lo    architectural HI/LO
//     rdata     HI for MFHI, LO for MFLO, otherwise 0 (combinational)
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_type,
    input  logic        cancel,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count;
    logic [31:0]   pendHi;
    logic [31:0]   pendLo;
    logic          pendWrite;
    logic [63:0]   sProd;
    logic [63:0]   uProd;
    logic [31:0]   divisor;
    logic          divOverflow;
    logic [31:0]   sQuo;
    logic [31:0]   sRem;
    logic [31:0]   uQuo;
    logic [31:0]   uRem;

    // Divide by zero never commits, so a safe divisor just keeps the arithmetic defined.
    assign divisor     = (rt_val == 32'h0) ? 32'h1 : rt_val;
    // INT_MIN / -1 overflows two's complement; pin the architectural answer explicitly.
    assign divOverflow = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);
    assign sProd = 64'($signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val}));
    assign uProd = {32'h0, rs_val} * {32'h0, rt_val};
    assign sQuo  = divOverflow ? 32'h8000_0000 : 32'($signed(rs_val) / $signed(divisor));
    assign sRem  = divOverflow ? 32'h0 : 32'($signed(rs_val) % $signed(divisor));
    assign uQuo  = rs_val / divisor;
    assign uRem  = rs_val % divisor;

    assign busy  = (count != '0);
    assign rdata = (mdu_type == MDU_MFHI) ? hi : (mdu_type == MDU_MFLO) ? lo : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendWrite <= 1'b0;
        end else if (busy) begin
            // New starts are dropped while busy; the in-flight op runs to completion.
            count <= count - 1'b1;
            if (count == CW'(1) && pendWrite) begin
                hi <= pendHi;
                lo <= pendLo;
            end
        end else if (start && !cancel) begin
            case (mdu_type)
                MDU_MULT: begin
                    {pendHi, pendLo} <= sProd;
                    pendWrite        <= 1'b1;
                    count            <= CW'(MULT_CYCLES);
                end
                MDU_MULTU: begin
                    {pendHi, pendLo} <= uProd;
                    pendWrite        <= 1'b1;
                    count            <= CW'(MULT_CYCLES);
                end
                MDU_DIV: begin
                    pendHi    <= sRem;
                    pendLo    <= sQuo;
                    pendWrite <= (rt_val != 32'h0);
                    count     <= CW'(DIV_CYCLES);
                end
                MDU_DIVU: begin
                    pendHi    <= uRem;
                    pendLo    <= uQuo;
                    pendWrite <= (rt_val != 32'h0);
                    count     <= CW'(DIV_CYCLES);
                end
                MDU_MTHI: hi <= rs_val;
                MDU_MTLO: lo <= rs_val;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed scoreboard bench for mdu_unit.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [3:0]  mduType = 4'd0;
    logic [31:0] rsVal = '0;
    logic [31:0] rtVal = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int compared = 0;
    int mismatched = 0;
    logic [63:0] sb[$];

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_type(mduType), .cancel(cancel),
        .rs_val(rsVal), .rt_val(rtVal), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one command for a single rising edge; returns at the following negedge.
    task automatic issue(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input logic c);
        start = 1'b1;
        mduType = t;
        rsVal = a;
        rtVal = b;
        cancel = c;
        @(negedge clk);
        start = 1'b0;
        cancel = 1'b0;
        mduType = 4'd0;
    endtask

    // Counts remaining busy cycles (bounded), then pops the expected {hi,lo}.
    task automatic waitDone(input string tag, input int expN);
        int n = 0;
        logic [63:0] e;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, 32'(n), 32'(expN));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_hi"}, hi, e[63:32]);
            check({tag, "_lo"}, lo, e[31:0]);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        longint p;
        // 1: reset after random state
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(4'd7, $urandom, 32'h0, 1'b0);
        issue(4'd8, $urandom, 32'h0, 1'b0);
        issue(4'd1, $urandom, $urandom, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        mduType = 4'd5;
        #1 check("rst_rdata_hi", rdata, 32'h0);
        mduType = 4'd6;
        #1 check("rst_rdata_lo", rdata, 32'h0);
        mduType = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        // 2: mult / multu
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        waitDone("mult", 5);
        sb.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        waitDone("multu", 5);
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            p = longint'($signed(a)) * longint'($signed(b));
            sb.push_back(p);
            issue(4'd1, a, b, 1'b0);
            waitDone("mult_rand", 5);
        end
        // 3: signed divide, edge cases, divide by zero
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        waitDone("div_neg", 10);
        sb.push_back({32'h0000_0001, 32'hFFFF_FFFD});
        issue(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0);
        waitDone("div_negdiv", 10);
        sb.push_back({32'h0, 32'h8000_0000});
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitDone("div_ovf", 10);
        issue(4'd7, 32'h11, 32'h0, 1'b0);
        issue(4'd8, 32'h22, 32'h0, 1'b0);
        sb.push_back({32'h11, 32'h22});
        issue(4'd4, 32'd7, 32'd0, 1'b0);
        waitDone("divu_zero", 10);
        // 4: mthi/mtlo back to back, then mfhi/mflo
        issue(4'd7, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("mthi_busy", 32'(busy), 32'd0);
        issue(4'd8, 32'h1234_5678, 32'h0, 1'b0);
        check("mtlo_busy", 32'(busy), 32'd0);
        mduType = 4'd5;
        #1 check("mfhi", rdata, 32'hDEAD_BEEF);
        mduType = 4'd6;
        #1 check("mflo", rdata, 32'h1234_5678);
        mduType = 4'd9;
        #1 check("rdata_other", rdata, 32'h0);
        mduType = 4'd0;
        // 5: cancel suppresses start; start while busy is dropped
        issue(4'd3, 32'd100, 32'd3, 1'b1);
        check("cancel_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("cancel_busy2", 32'(busy), 32'd0);
        check("cancel_hi", hi, 32'hDEAD_BEEF);
        check("cancel_lo", lo, 32'h1234_5678);
        sb.push_back({32'd2, 32'd14});
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        issue(4'd1, 32'd5, 32'd5, 1'b0);
        check("drop_busy", 32'(busy), 32'd1);
        waitDone("div_drop", 7);
        @(negedge clk);
        check("drop_no_restart", 32'(busy), 32'd0);
        // 6: reset mid-mult discards the pending result
        issue(4'd1, 32'd3, 32'd4, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        repeat (6) @(negedge clk);
        check("midrst_late_lo", lo, 32'h0);
        check("midrst_late_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
